pipe_reg_elastic: RTL and testbench
===================================

// Module: pipe_reg_elastic
//
// PURPOSE
// - Parametrised elastic pipeline register chain with valid/ready flow control.
// - Next generation of the fixed-width DFF stages: one module, any WIDTH, any DEPTH.
// - Adds backpressure, bubble collapsing and an occupancy count.
// - Used between arithmetic stages, e.g. mantissa/exponent paths, where the next stage may stall.
//
// PARAMETERS
// - WIDTH  16  data bits per stage (>=1)
// - DEPTH  3   number of register stages (>=1); no-stall latency in cycles
// - OCC_W  $clog2(DEPTH+1)  width of occ (localparam, derived)
//
// PORTS
// - clk        in   1      clock; all state updates on posedge
// - rstn       in   1      reset, synchronous, active-low
// - in_valid   in   1      upstream beat present
// - in_data    in   WIDTH  upstream data
// - in_ready   out  1      stage 0 can load this cycle
// - out_valid  out  1      last stage holds a beat
// - out_data   out  WIDTH  last-stage data
// - out_ready  in   1      downstream accepts
// - occ        out  OCC_W  number of valid stages
// - flush      in   1      drop all contents; present only with PIPE_FLUSH_EN
//
// BEHAVIOUR
// - Reset, clk and rstn: synchronous, active-low reset rstn on clock clk.
//   - rstn=0 clears v[k]=0 and d[k]=0 for all stages, and occ=0.
//   - Reset dominates every other input, flush included.
// - State: v[k] and d[k] for k=0..DEPTH-1; stage DEPTH-1 is the output.
//   - out_valid=v[DEPTH-1]; out_data=d[DEPTH-1] (registered, no comb path from in_data).
// - Load enables, combinational ripple from the output back:
//   - ld[DEPTH-1] = !v[DEPTH-1] | out_ready
//   - ld[k] = !v[k] | ld[k+1]
//   - in_ready = ld[0]. in_ready may depend combinationally on out_ready; this is permitted.
// - On posedge, for each k with ld[k]=1:
//   - v[k] <= src_v, where src_v = in_valid for k=0, else v[k-1].
//   - d[k] <= src_d only when src_v=1; otherwise d[k] holds (no toggling on bubbles).
// - Stages with ld[k]=0 hold both v[k] and d[k].
// - Handshakes:
//   - Input accepted iff in_valid & in_ready.
//   - Output consumed iff out_valid & out_ready.
// - Latency and throughput:
//   - Accepted beat reaches out_valid exactly DEPTH cycles later when out_ready stays 1.
//   - Throughput is 1 beat/cycle.
// - Bubbles collapse: an empty stage always loads, so a stalled output packs beats contiguously behind it.
// - Full: all v=1 and out_ready=0 gives in_ready=0; nothing accepted, nothing lost.
// - Full with out_ready=1: in_ready=1; simultaneous accept and consume, occ unchanged.
// - Empty: out_valid=0, in_ready=1 regardless of out_ready.
// - occ is registered; it equals the popcount of v every cycle:
//   - +1 on accept only; -1 on consume only; unchanged on both or neither.
//   - Range 0..DEPTH; never wraps.
// - Ordering: strict FIFO; no duplication, no drop (except flush).
// - in_valid must hold with stable in_data until accepted. out_valid/out_data obey the same rule once asserted (except flush/reset).
//
// CONFIGURATION
// - PIPE_FLUSH_EN defined:
//   - flush port exists. flush=1 on posedge clears all v and occ to 0; d holds.
//   - A beat presented that cycle is discarded even if in_ready=1.
//   - An output handshake in the flush cycle counts as consumed.
// - PIPE_FLUSH_EN undefined: no flush port, no flush logic; contents leave only via output or reset.
//
// TESTING (WIDTH=16, DEPTH=3 unless noted)
// - Reset: rstn=0 for 2 cycles, random inputs -> out_valid=0, out_data=16'h0000, occ=0, in_ready=1.
// - Stream: out_ready=1, in_valid=1, in_data=16'h0001..16'h0010 on consecutive cycles
//   -> out_data 16'h0001..16'h0010 on consecutive cycles starting 3 cycles after the first accept; in_ready always 1.
// - Backpressure: out_ready=0, feed 16'hA000..16'hA004 -> 3 accepted, occ=3, in_ready=0;
//   then out_ready=1 -> 16'hA000..16'hA004 exit in order, none lost or duplicated.
// - Bubble collapse: out_ready=0; send 16'h1111, idle 2 cycles, send 16'h2222
//   -> occ=2; out_data=16'h1111 first, then 16'h2222 on the next cycle after out_ready=1.
// - Reset mid-operation: occ=2, out_valid=1, rstn=0 for 1 cycle -> next cycle occ=0, out_valid=0, out_data=0.
// - Flush (PIPE_FLUSH_EN, DEPTH=4): occ=4, flush=1 with in_valid=1, in_data=16'hBEEF
//   -> next cycle occ=0, out_valid=0; 16'hBEEF never appears at the output.

Source files
------------

// File: rtl/pipe_reg_elastic_if.sv
// rtl/pipe_reg_elastic_if.sv - valid/ready handshake bundle for pipe_reg_elastic
// master drives the upstream beat and downstream ready; slave is the pipeline.
interface pipe_reg_elastic_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic valid/ready register chain, WIDTH x DEPTH, with occupancy
// Optional PIPE_FLUSH_EN adds a flush input that drops all held beats.
module pipe_reg_elastic #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 3,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
`ifdef PIPE_FLUSH_EN
   input  logic             flush,
`endif
   pipe_reg_elastic_if.slave bus,
   output logic [OCC_W-1:0] occ
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [DEPTH-1:0] ld;
   logic             acc, cons;

   // Load enables ripple from the output back: an empty stage always loads.
   always_comb begin
      logic nxt;
      ld  = '0;
      nxt = bus.out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         ld[k] = !v_q[k] | nxt;
         nxt   = ld[k];
      end
   end

   assign acc           = bus.in_valid & ld[0];
   assign cons          = v_q[DEPTH-1] & bus.out_ready;
   assign bus.in_ready  = ld[0];
   assign bus.out_valid = v_q[DEPTH-1];
   assign bus.out_data  = d_q[DEPTH-1];
   assign occ           = occ_q;

   always_comb begin
      logic             pv;
      logic [WIDTH-1:0] pd;
      v_d   = v_q;
      d_d   = d_q;
      occ_d = occ_q;
      pv    = bus.in_valid;
      pd    = bus.in_data;
      for (int k = 0; k < DEPTH; k++) begin
         if (ld[k]) begin
            v_d[k] = pv;
            // Data only moves with a valid beat so bubbles leave registers quiet.
            if (pv) begin
               d_d[k] = pd;
            end
         end
         pv = v_q[k];
         pd = d_q[k];
      end
      if (acc && !cons) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!acc && cons) begin
         occ_d = occ_q - OCC_W'(1);
      end
`ifdef PIPE_FLUSH_EN
      if (flush) begin
         v_d   = '0;
         d_d   = d_q;
         occ_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q   <= '0;
         occ_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         d_q   <= d_d;
         occ_q <= occ_d;
      end
   end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - self-checking bench for pipe_reg_elastic
// Reference model tracks each beat's stage position in a queue.
module tb_pipe_reg_elastic;
   localparam int WIDTH = 16;
`ifdef PIPE_FLUSH_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 3;
`endif
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [WIDTH-1:0] data;
      int               pos;
   } beat_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             flush;
   logic [OCC_W-1:0] occ;

   pipe_reg_elastic_if #(.WIDTH(WIDTH)) bus ();

   pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
`ifdef PIPE_FLUSH_EN
      .flush(flush),
`endif
      .bus  (bus.slave),
      .occ  (occ)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_errors = 0;
   beat_t            q[$];
   logic [WIDTH-1:0] last_out = '0;
   logic [WIDTH-1:0] out_log[$];
   bit               model_live = 0;
   bit               last_acc = 0;
   int               cyc = 0;
   int               first_acc = -1;
   int               first_out = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      bit acc, cons, rs, fl, exp_ov, exp_ir;
      int prev, np;
      @(negedge clk);
      #1;
      exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
      exp_ir = (q.size() < DEPTH) || bus.out_ready;
      if (model_live) begin
         check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
         check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ir});
         check("occ", 32'(occ), 32'(q.size()));
         check("out_data", 32'(bus.out_data), 32'(last_out));
      end
      rs   = rstn;
      fl   = flush;
      acc  = model_live && rs && bus.in_valid && exp_ir;
      cons = model_live && rs && exp_ov && bus.out_ready;
      last_acc = acc;
      if (cons) out_log.push_back(bus.out_data);
      if (acc && !fl && first_acc < 0) first_acc = cyc;
      if (model_live && bus.out_valid && first_out < 0) first_out = cyc;
      @(posedge clk);
      if (!rs) begin
         q.delete();
         last_out   = '0;
         model_live = 1;
      end else if (fl) begin
         q.delete();
      end else if (model_live) begin
         if (cons) void'(q.pop_front());
         prev = DEPTH;
         foreach (q[i]) begin
            np = (q[i].pos + 1 < prev) ? q[i].pos + 1 : q[i].pos;
            if (np == DEPTH - 1 && q[i].pos != DEPTH - 1) last_out = q[i].data;
            q[i].pos = np;
            prev = np;
         end
         if (acc) begin
            q.push_back('{data: bus.in_data, pos: 0});
            if (DEPTH == 1) last_out = bus.in_data;
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      int i;
      rstn          = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 16'($urandom);
      bus.out_ready = 1'($urandom);
      step();
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 16'($urandom);
      step();
      rstn          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'h0000);
      check("rst_occ", 32'(occ), 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // Stream
      first_acc = -1;
      first_out = -1;
      out_log.delete();
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(k);
         step();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < DEPTH + 2; k++) step();
      check("stream_latency", 32'(first_out - first_acc), 32'(DEPTH));
      check("stream_count", 32'(out_log.size()), 32'd16);
      foreach (out_log[k]) check("stream_order", 32'(out_log[k]), 32'(k + 1));

      // Backpressure
      out_log.delete();
      bus.out_ready = 1'b0;
      i = 0;
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = (i < 5);
         bus.in_data  = 16'hA000 + 16'(i);
         step();
         if (last_acc) i++;
      end
      bus.in_valid = (i < 5);
      bus.in_data  = 16'hA000 + 16'(i);
      #1;
      check("bp_accepted", 32'(i), 32'(DEPTH));
      check("bp_occ", 32'(occ), 32'(DEPTH));
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         bus.in_valid = (i < 5);
         bus.in_data  = 16'hA000 + 16'(i);
         step();
         if (last_acc) i++;
      end
      bus.in_valid = 1'b0;
      check("bp_count", 32'(out_log.size()), 32'd5);
      foreach (out_log[k]) check("bp_order", 32'(out_log[k]), 32'hA000 + 32'(k));

      // Bubble collapse
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h1111;
      step();
      bus.in_valid  = 1'b0;
      step();
      step();
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h2222;
      step();
      bus.in_valid  = 1'b0;
      for (int k = 0; k < DEPTH; k++) step();
      check("bub_occ", 32'(occ), 32'd2);
      check("bub_first", 32'(bus.out_data), 32'h1111);
      bus.out_ready = 1'b1;
      step();
      check("bub_second_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bub_second", 32'(bus.out_data), 32'h2222);
      step();

      // Reset mid-operation
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h5A00 + 16'(k);
         step();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) step();
      check("mid_occ_before", 32'(occ), 32'd2);
      check("mid_valid_before", {31'b0, bus.out_valid}, 32'd1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      check("mid_occ", 32'(occ), 32'd0);
      check("mid_valid", {31'b0, bus.out_valid}, 32'd0);
      check("mid_data", 32'(bus.out_data), 32'd0);

`ifdef PIPE_FLUSH_EN
      bus.out_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'hC000 + 16'(k);
         step();
      end
      bus.in_valid = 1'b0;
      step();
      check("fl_occ_full", 32'(occ), 32'(DEPTH));
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBEEF;
      flush        = 1'b1;
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("fl_occ", 32'(occ), 32'd0);
      check("fl_valid", {31'b0, bus.out_valid}, 32'd0);
      out_log.delete();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 2 * DEPTH; k++) step();
      check("fl_no_beef", 32'(out_log.size()), 32'd0);
`endif

      // Randomized traffic under varying backpressure
      bus.in_valid = 1'b0;
      for (int blk = 0; blk < 15; blk++) begin
         int rdy_pct;
         rdy_pct = int'($urandom_range(0, 100));
         for (int k = 0; k < 200; k++) begin
            if (!bus.in_valid || last_acc) begin
               bus.in_valid = ($urandom_range(0, 3) != 0);
               bus.in_data  = 16'($urandom);
            end
            bus.out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            rstn          = ($urandom_range(0, 499) != 0);
`ifdef PIPE_FLUSH_EN
            flush         = ($urandom_range(0, 59) == 0);
`endif
            step();
         end
      end
      rstn  = 1'b1;
      flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
